// File: rtl/ahb_sync_req.sv
// AHB-side four-phase req/ack initiator with a one-deep shadow for writes that arrive mid-transfer.
// Optional handshake abort is compiled in when the macro TIMEOUT_EN is defined.
module ahb_sync_req #(
  parameter int ADDR_WIDTH     = 6,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cfg_wr,
  input  logic [ADDR_WIDTH-1:0] DADR_I,
  input  logic [ADDR_WIDTH-1:0] CADR_I,
  input  logic                  DLEN_I,
  input  logic                  DBIT_I,
  output logic                  req,
  input  logic                  ack,
  output logic [ADDR_WIDTH-1:0] DADR,
  output logic [ADDR_WIDTH-1:0] CADR,
  output logic                  DLEN,
  output logic                  DBIT,
  output logic                  busy,
  output logic                  pending,
  output logic                  done,
  output logic                  overrun,
  output logic                  err_timeout
);
  localparam int XW = 2 * ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [XW-1:0]          hold_q;
  logic [XW-1:0]          shadow_q;
  logic [XW-1:0]          cfg_in;
  logic                   req_q;
  logic                   pending_q;
  logic                   done_q;
  logic                   overrun_q;
  logic                   err_timeout_q;
  logic                   ack_s;
  logic                   exit_rel;
  logic                   relaunch;
  logic                   timeout_hit;

  generate
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("ahb_sync_req: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  assign cfg_in   = {DADR_I, CADR_I, DLEN_I, DBIT_I};
  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign exit_rel = (state_q == REL) && !ack_s;
  assign relaunch = exit_rel && (pending_q || cfg_wr);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
    end
  end

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Counter measures the whole REQ+REL round trip; a relaunch starts a fresh budget.
  assign timeout_hit = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || relaunch) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      shadow_q      <= '0;
      req_q         <= 1'b0;
      pending_q     <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_wr) begin
            hold_q  <= cfg_in;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ, REL: begin
          if (timeout_hit) begin
            req_q         <= 1'b0;
            pending_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else if (exit_rel) begin
            done_q <= 1'b1;
            // The shadow is older than a same-edge write, so it goes out first.
            if (pending_q) begin
              hold_q  <= shadow_q;
              req_q   <= 1'b1;
              state_q <= REQ;
              if (cfg_wr) begin
                shadow_q <= cfg_in;
              end else begin
                pending_q <= 1'b0;
              end
            end else if (relaunch) begin
              hold_q  <= cfg_in;
              req_q   <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            if (state_q == REQ && ack_s) begin
              req_q   <= 1'b0;
              state_q <= REL;
            end
            if (cfg_wr) begin
              shadow_q  <= cfg_in;
              pending_q <= 1'b1;
              overrun_q <= pending_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {DADR, CADR, DLEN, DBIT} = hold_q;
  assign req         = req_q;
  assign busy        = (state_q != IDLE);
  assign pending     = pending_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign err_timeout = err_timeout_q;

endmodule
